// File: rtl/packer_if.sv
// rtl/packer_if.sv - valid/ready stream bundle carrying data and an end-of-frame marker
interface packer_if #(
   parameter int width_p = 8
);
   logic [width_p-1:0] tdata;
   logic               tlast;
   logic               tvalid;
   logic               tready;

   modport master (output tdata, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/packer.sv
// rtl/packer.sv - packs num_packed_p narrow elements LSB-first into one registered output word
module packer #(
   parameter int unpacked_p   = 2,
   parameter int num_packed_p = 4,
   parameter int bus_width_p  = unpacked_p * num_packed_p
) (
   input  logic      clk_i,
   input  logic      reset_ni,
   packer_if.slave   in_s,
   packer_if.master  out_m
);
   localparam int cnt_w = $clog2(num_packed_p);

   if (bus_width_p != unpacked_p * num_packed_p) begin : g_bad_width
      $error("packer: bus_width_p must equal unpacked_p*num_packed_p");
   end
   if (num_packed_p < 2 || (num_packed_p & (num_packed_p - 1)) != 0) begin : g_bad_num
      $error("packer: num_packed_p must be a power of two >= 2");
   end

   logic [bus_width_p-1:0] acc_r;
   logic [cnt_w-1:0]       count_r;
   logic [bus_width_p-1:0] out_r;
   logic                   out_valid_r;
   logic                   out_last_r;

   logic                   ready;
   logic                   in_fire;
   logic                   out_fire;
   logic                   word_done;
   logic [bus_width_p-1:0] merged;
   logic [bus_width_p-1:0] flushed;

   // Input readiness looks only at the output register, so a stalled word freezes the accumulator.
   assign ready     = !out_valid_r || out_m.tready;
   assign in_fire   = in_s.tvalid && ready;
   assign out_fire  = out_valid_r && out_m.tready;
   assign word_done = in_fire && ((count_r == cnt_w'(num_packed_p - 1)) || in_s.tlast);

   always_comb begin
      merged  = acc_r;
      flushed = '0;
      for (int e = 0; e < num_packed_p; e++) begin
         if (e == int'(count_r)) begin
            merged[e*unpacked_p +: unpacked_p] = in_s.tdata;
         end
      end
      for (int e = 0; e < num_packed_p; e++) begin
         if (e <= int'(count_r)) begin
            flushed[e*unpacked_p +: unpacked_p] = merged[e*unpacked_p +: unpacked_p];
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         acc_r       <= '0;
         count_r     <= '0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else begin
         if (out_fire) begin
            out_valid_r <= 1'b0;
         end
         // A completing element in the same cycle as out_fire reloads the word with no bubble.
         if (in_fire) begin
            if (word_done) begin
               out_r       <= flushed;
               out_last_r  <= in_s.tlast;
               out_valid_r <= 1'b1;
               acc_r       <= '0;
               count_r     <= '0;
            end else begin
               acc_r   <= merged;
               count_r <= count_r + 1'b1;
            end
         end
      end
   end

   assign in_s.tready  = ready;
   assign out_m.tdata  = out_r;
   assign out_m.tvalid = out_valid_r;
   assign out_m.tlast  = out_last_r;
endmodule

// File: tb/tb_packer.sv
// tb/tb_packer.sv - scoreboard bench for packer with directed word vectors and stalled round trip
module tb_packer;
   logic clk_i = 1'b0;
   logic reset_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   packer_if #(.width_p(2)) in_if ();
   packer_if #(.width_p(8)) out_if ();

   packer #(.unpacked_p(2), .num_packed_p(4), .bus_width_p(8)) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .in_s     (in_if),
      .out_m    (out_if)
   );

   int n_vec = 0;
   int n_bad = 0;
   int stalls = 0;
   int cyc = 0;
   logic [8:0] exp_q[$];
   int fire_cyc[$];
   logic rt_done;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] w, input logic l);
      exp_q.push_back({l, w});
   endtask

   // Monitor: every accepted output word is compared against the head of the scoreboard.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk_i);
         if (reset_ni && out_if.tvalid && out_if.tready) begin
            fire_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               check("unexpected_word", {23'd0, out_if.tlast, out_if.tdata}, 32'h1ff);
            end else begin
               e = exp_q.pop_front();
               check("word_data", {24'd0, out_if.tdata}, {24'd0, e[7:0]});
               check("word_last", {31'd0, out_if.tlast}, {31'd0, e[8]});
            end
         end
      end
   end

   task automatic send(input logic [1:0] d, input logic l);
      int n;
      n = 0;
      in_if.tdata  = d;
      in_if.tlast  = l;
      in_if.tvalid = 1'b1;
      @(negedge clk_i);
      while (!in_if.tready) begin
         stalls++;
         n++;
         if (n > 200) begin
            check("send_timeout", 32'd0, 32'd1);
            in_if.tvalid = 1'b0;
            return;
         end
         @(negedge clk_i);
      end
      @(posedge clk_i);
      #1;
      in_if.tvalid = 1'b0;
      in_if.tlast  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk_i);
         n++;
      end
      @(posedge clk_i);
      #1;
      check("drain_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      in_if.tdata   = 2'd0;
      in_if.tlast   = 1'b0;
      in_if.tvalid  = 1'b0;
      out_if.tready = 1'b0;
      rt_done       = 1'b0;

      // Reset state
      repeat (2) @(negedge clk_i);
      check("rst_valid_o", {31'd0, out_if.tvalid}, 32'd0);
      check("rst_packed_o", {24'd0, out_if.tdata}, 32'd0);
      check("rst_last_o", {31'd0, out_if.tlast}, 32'd0);
      check("rst_ready_o", {31'd0, in_if.tready}, 32'd1);
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      out_if.tready = 1'b1;

      // Basic pack 1,2,3,0 -> 0x39 visible one edge after the fourth accept
      push(8'h39, 1'b0);
      send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0);
      @(negedge clk_i);
      check("basic_latency_valid", {31'd0, out_if.tvalid}, 32'd1);
      drain();

      // Partial flush, then count restarts at index 0
      push(8'h0F, 1'b1);
      send(2'd3, 1'b0); send(2'd3, 1'b1);
      push(8'h80, 1'b0);
      send(2'd0, 1'b0); send(2'd0, 1'b0); send(2'd0, 1'b0); send(2'd2, 1'b0);
      drain();

      // Backpressure: word held stable, stalled element accepted first after release
      out_if.tready = 1'b0;
      push(8'h39, 1'b0);
      send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0); send(2'd0, 1'b0);
      push(8'hAA, 1'b0);
      fork
         send(2'd2, 1'b0);
         begin
            repeat (5) begin
               @(negedge clk_i);
               check("bp_ready_o_low", {31'd0, in_if.tready}, 32'd0);
               check("bp_packed_stable", {24'd0, out_if.tdata}, 32'h39);
            end
            @(posedge clk_i);
            #1;
            out_if.tready = 1'b1;
         end
      join
      send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd2, 1'b0);
      drain();

      // Throughput: 8 back-to-back elements, words 4 cycles apart
      stalls = 0;
      fire_cyc.delete();
      push(8'hE4, 1'b0);
      push(8'h1B, 1'b0);
      send(2'd0, 1'b0); send(2'd1, 1'b0); send(2'd2, 1'b0); send(2'd3, 1'b0);
      send(2'd3, 1'b0); send(2'd2, 1'b0); send(2'd1, 1'b0); send(2'd0, 1'b0);
      drain();
      check("tp_no_stall", stalls, 32'd0);
      check("tp_word_count", fire_cyc.size(), 32'd2);
      if (fire_cyc.size() == 2) begin
         check("tp_spacing", fire_cyc[1] - fire_cyc[0], 32'd4);
      end

      // Asynchronous reset with a held word drops valid_o immediately
      out_if.tready = 1'b0;
      send(2'd3, 1'b0); send(2'd3, 1'b0); send(2'd3, 1'b0); send(2'd3, 1'b0);
      @(negedge clk_i);
      check("held_valid_o", {31'd0, out_if.tvalid}, 32'd1);
      #2;
      reset_ni = 1'b0;
      #1;
      check("async_rst_valid_o", {31'd0, out_if.tvalid}, 32'd0);
      check("async_rst_packed_o", {24'd0, out_if.tdata}, 32'd0);
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      out_if.tready = 1'b1;

      // Reset mid-word discards the partial accumulator
      send(2'd1, 1'b0); send(2'd1, 1'b0);
      #2;
      reset_ni = 1'b0;
      #1;
      check("midword_rst_valid_o", {31'd0, out_if.tvalid}, 32'd0);
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      push(8'hAA, 1'b0);
      send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd2, 1'b0); send(2'd2, 1'b0);
      drain();

      // Round trip with random elements, random last, random stalls and idle garbage
      fork
         begin
            while (!rt_done) begin
               @(posedge clk_i);
               #1;
               if (!rt_done) out_if.tready = ($urandom_range(0, 2) != 0);
            end
         end
         begin
            logic [7:0] w;
            int idx;
            logic [1:0] e;
            logic l;
            w = 8'd0;
            idx = 0;
            for (int i = 0; i < 40; i++) begin
               e = 2'($urandom_range(0, 3));
               l = (i == 39) || ($urandom_range(0, 4) == 0);
               case (idx)
                  0: w[1:0] = e;
                  1: w[3:2] = e;
                  2: w[5:4] = e;
                  default: w[7:6] = e;
               endcase
               if (idx == 3 || l) begin
                  push(w, l);
                  w = 8'd0;
                  idx = 0;
               end else begin
                  idx++;
               end
               send(e, l);
               if ($urandom_range(0, 3) == 0) begin
                  in_if.tdata = 2'($urandom_range(0, 3));
                  in_if.tlast = 1'b1;
                  @(posedge clk_i);
                  #1;
                  in_if.tlast = 1'b0;
               end
            end
            rt_done = 1'b1;
         end
      join
      out_if.tready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
